next_key_queue: RTL and testbench

Buffers NeXT keyboard key events coming out of the sound-box protocol block (the 16-bit keycode and its one-cycle valid strobe) into a small first-word-fall-through queue, adds typematic auto-repeat for the most recently pressed key, and presents events to the host controller through a pop handshake. It sits directly downstream of the sound-box top-level in the `mon_clk` domain and feeds the system controller that maps keys to menu/remote commands.

---
 rtl/next_key_queue_if.sv | 26 ++
 rtl/next_key_queue.sv | 127 ++++++++++++
 tb/tb_next_key_queue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/next_key_queue_if.sv
// Key-event bus between the sound-box keycode source, the event queue and the host consumer.
// kc_valid is a one-cycle strobe qualifying kc_in; the host takes the head entry by asserting ev_pop while ev_valid=1.
interface next_key_queue_if #(
    parameter int AW = 3
);
    logic [15:0] kc_in;
    logic        kc_valid;
    logic [16:0] ev_data;
    logic        ev_valid;
    logic        ev_pop;
    logic [AW:0] count;
    logic        ovf;
    logic        ovf_clr;
    logic        held_valid;
    logic [6:0]  held_key;

    modport master (
        output kc_in, kc_valid, ev_pop, ovf_clr,
        input  ev_data, ev_valid, count, ovf, held_valid, held_key
    );

    modport slave (
        input  kc_in, kc_valid, ev_pop, ovf_clr,
        output ev_data, ev_valid, count, ovf, held_valid, held_key
    );
endinterface

// File: rtl/next_key_queue.sv
// FWFT queue of NeXT keyboard events with typematic auto-repeat of the most recently made key.
// Input events win the single push port; a colliding repeat waits in a one-deep pending flag.
module next_key_queue #(
    parameter int DEPTH        = 8,
    parameter int AW           = 3,
    parameter int REPEAT_DELAY = 2500000,
    parameter int REPEAT_RATE  = 165000,
    parameter int TW           = 22
) (
    input  logic            mon_clk,
    input  logic            reset,
    next_key_queue_if.slave kq
);
    localparam logic [TW-1:0] DLY_LD   = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LD  = TW'(REPEAT_RATE - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [16:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_held_valid;
    logic [6:0]    r_held_key;
    logic [7:0]    r_rep_mod;
    logic [TW-1:0] r_timer;
    logic          r_pend;

    logic [6:0]    w_key;
    logic          w_make;
    logic          w_brk;
    logic          w_dup;
    logic          w_in_push;
    logic          w_set_held;
    logic          w_clr_held;
    logic          w_rep_req;
    logic          w_rep_push;
    logic          w_push;
    logic [16:0]   w_push_data;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_drop;

    always_comb begin
        w_key       = kq.kc_in[6:0];
        w_make      = kq.kc_valid & ~kq.kc_in[7];
        w_brk       = kq.kc_valid & kq.kc_in[7];
        w_dup       = w_make & r_held_valid & (r_held_key == w_key);
        w_in_push   = kq.kc_valid & ~w_dup;
        // key 0 is a modifier-only report and never becomes the held key
        w_set_held  = w_make & ~w_dup & (w_key != 7'd0);
        w_clr_held  = w_brk & r_held_valid & (w_key == r_held_key);
        w_rep_req   = r_held_valid & (r_timer == '0) & ~w_set_held & ~w_clr_held;
        w_rep_push  = ~w_in_push & (r_pend | w_rep_req);
        w_push      = w_in_push | w_rep_push;
        w_push_data = w_in_push ? {1'b0, kq.kc_in} : {1'b1, r_rep_mod, 1'b0, r_held_key};
        w_pop       = kq.ev_pop & (r_count != '0);
        w_full      = (r_count == FULL_CNT);
        w_wr        = w_push & (~w_full | w_pop);
        w_drop      = w_push & w_full & ~w_pop;
    end

    always_ff @(posedge mon_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge mon_clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_held_valid <= 1'b0;
            r_held_key   <= '0;
            r_rep_mod    <= '0;
            r_timer      <= '0;
            r_pend       <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (kq.ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_set_held) begin
                r_held_valid <= 1'b1;
                r_held_key   <= w_key;
                r_rep_mod    <= kq.kc_in[15:8];
                r_timer      <= DLY_LD;
            end else begin
                if (w_clr_held) begin
                    r_held_valid <= 1'b0;
                end
                if (r_held_valid) begin
                    r_timer <= (r_timer == '0) ? RATE_LD : r_timer - TW'(1);
                end
            end

            // a deferred repeat belongs to the old held key, so a held-key change drops it
            if (w_set_held | w_clr_held) begin
                r_pend <= 1'b0;
            end else if (w_in_push & (w_rep_req | r_pend)) begin
                r_pend <= 1'b1;
            end else if (w_rep_push) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign kq.ev_data    = (r_count == '0) ? 17'd0 : r_mem[r_rd_ptr];
    assign kq.ev_valid   = (r_count != '0);
    assign kq.count      = r_count;
    assign kq.ovf        = r_ovf;
    assign kq.held_valid = r_held_valid;
    assign kq.held_key   = r_held_key;
endmodule

// File: tb/tb_next_key_queue.sv
// Directed bench for next_key_queue with shortened repeat timing (delay 20, rate 6).
// Inputs change on the falling edge; outputs are checked on the falling edge after the sampling edge.
module tb_next_key_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int RD    = 20;
    localparam int RR    = 6;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [16:0] exp_q [$];

    next_key_queue_if #(.AW(AW)) kq ();

    next_key_queue #(
        .DEPTH(DEPTH), .AW(AW), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TW(8)
    ) dut (
        .mon_clk(clk),
        .reset  (reset),
        .kq     (kq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] kc);
        kq.kc_in    = kc;
        kq.kc_valid = 1'b1;
        @(negedge clk);
        kq.kc_valid = 1'b0;
        kq.kc_in    = 16'h0000;
    endtask

    task automatic pop1();
        kq.ev_pop = 1'b1;
        @(negedge clk);
        kq.ev_pop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_valid%0d", tag, i), 32'(kq.ev_valid), 32'd1);
            check_eq($sformatf("%s_data%0d", tag, i), 32'(kq.ev_data), 32'(exp_q.pop_front()));
            pop1();
        end
        check_eq($sformatf("%s_empty", tag), 32'(kq.count), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        kq.kc_in    = 16'h0000;
        kq.kc_valid = 1'b0;
        kq.ev_pop   = 1'b0;
        kq.ovf_clr  = 1'b0;
        idle(2);
        reset = 1'b0;

        check_eq("rst_ev_valid", 32'(kq.ev_valid), 32'd0);
        check_eq("rst_count", 32'(kq.count), 32'd0);
        check_eq("rst_ovf", 32'(kq.ovf), 32'd0);
        check_eq("rst_held_valid", 32'(kq.held_valid), 32'd0);
        check_eq("rst_held_key", 32'(kq.held_key), 32'd0);
        check_eq("rst_ev_data", 32'(kq.ev_data), 32'd0);

        // single make, then pop
        strobe(16'h0031);
        check_eq("t1_ev_valid", 32'(kq.ev_valid), 32'd1);
        check_eq("t1_ev_data", 32'(kq.ev_data), 32'h00031);
        check_eq("t1_count", 32'(kq.count), 32'd1);
        check_eq("t1_held_key", 32'(kq.held_key), 32'h31);
        check_eq("t1_held_valid", 32'(kq.held_valid), 32'd1);
        pop1();
        check_eq("t1_pop_empty", 32'(kq.ev_valid), 32'd0);
        do_reset();

        // hold through three repeats, then release
        strobe(16'h0031);
        idle(RD - 1);
        check_eq("t2_rep_not_early", 32'(kq.count), 32'd1);
        idle(1);
        check_eq("t2_first_rep", 32'(kq.count), 32'd2);
        idle(2 * RR);
        check_eq("t2_third_rep", 32'(kq.count), 32'd4);
        idle(1);
        strobe(16'h00B1);
        check_eq("t2_held_cleared", 32'(kq.held_valid), 32'd0);
        check_eq("t2_count", 32'(kq.count), 32'd5);
        exp_q.push_back(17'h00031);
        exp_q.push_back(17'h10031);
        exp_q.push_back(17'h10031);
        exp_q.push_back(17'h10031);
        exp_q.push_back(17'h000B1);
        drain_check("t2");
        idle(30);
        check_eq("t2_no_rep_after_break", 32'(kq.count), 32'd0);
        do_reset();

        // duplicate make is dropped and leaves the repeat phase alone
        strobe(16'h0031);
        strobe(16'h0031);
        check_eq("t3_dup_dropped", 32'(kq.count), 32'd1);
        idle(RD - 2);
        check_eq("t3_phase_not_early", 32'(kq.count), 32'd1);
        idle(1);
        check_eq("t3_phase_kept", 32'(kq.count), 32'd2);
        do_reset();

        // fill, overflow, push+pop while full, ovf clear and set-wins
        for (int i = 1; i <= DEPTH; i++) strobe(16'h0080 | 16'(i));
        check_eq("t4_full_count", 32'(kq.count), 32'd8);
        check_eq("t4_no_ovf_yet", 32'(kq.ovf), 32'd0);
        strobe(16'h0089);
        check_eq("t4_drop_count", 32'(kq.count), 32'd8);
        check_eq("t4_drop_ovf", 32'(kq.ovf), 32'd1);
        check_eq("t4_drop_head", 32'(kq.ev_data), 32'h00081);
        kq.ev_pop = 1'b1;
        strobe(16'h008A);
        kq.ev_pop = 1'b0;
        check_eq("t4_pushpop_count", 32'(kq.count), 32'd8);
        check_eq("t4_pushpop_ovf", 32'(kq.ovf), 32'd1);
        check_eq("t4_pushpop_head", 32'(kq.ev_data), 32'h00082);
        kq.ovf_clr = 1'b1;
        idle(1);
        kq.ovf_clr = 1'b0;
        check_eq("t4_ovf_clr", 32'(kq.ovf), 32'd0);
        kq.ovf_clr = 1'b1;
        strobe(16'h008B);
        kq.ovf_clr = 1'b0;
        check_eq("t4_set_wins", 32'(kq.ovf), 32'd1);
        for (int i = 2; i <= DEPTH; i++) exp_q.push_back(17'h00080 | 17'(i));
        exp_q.push_back(17'h0008A);
        drain_check("t4");
        pop1();
        check_eq("t4_pop_empty", 32'(kq.count), 32'd0);
        kq.ev_pop = 1'b1;
        strobe(16'h0090);
        kq.ev_pop = 1'b0;
        check_eq("t4_pushpop_empty_cnt", 32'(kq.count), 32'd1);
        check_eq("t4_pushpop_empty_head", 32'(kq.ev_data), 32'h00090);
        do_reset();

        // repeat expiry colliding with a break of another key
        strobe(16'h0031);
        idle(RD - 1);
        strobe(16'h00A5);
        check_eq("t5_collide_count", 32'(kq.count), 32'd2);
        check_eq("t5_held_kept", 32'(kq.held_valid), 32'd1);
        idle(1);
        check_eq("t5_deferred_count", 32'(kq.count), 32'd3);
        exp_q.push_back(17'h00031);
        exp_q.push_back(17'h000A5);
        exp_q.push_back(17'h10031);
        drain_check("t5");
        do_reset();

        // modifiers latched into repeats; key-0 report leaves held key alone
        strobe(16'h0431);
        strobe(16'h0200);
        check_eq("t6_held_key", 32'(kq.held_key), 32'h31);
        idle(RD - 2);
        check_eq("t6_not_early", 32'(kq.count), 32'd2);
        idle(1);
        check_eq("t6_rep_count", 32'(kq.count), 32'd3);
        exp_q.push_back(17'h00431);
        exp_q.push_back(17'h00200);
        exp_q.push_back(17'h10431);
        drain_check("t6");
        do_reset();

        // reset mid-operation
        strobe(16'h0031);
        for (int i = 1; i <= 4; i++) strobe(16'h0080 | 16'(i));
        check_eq("t7_pre_count", 32'(kq.count), 32'd5);
        check_eq("t7_pre_held", 32'(kq.held_valid), 32'd1);
        do_reset();
        check_eq("t7_count", 32'(kq.count), 32'd0);
        check_eq("t7_ev_valid", 32'(kq.ev_valid), 32'd0);
        check_eq("t7_held_valid", 32'(kq.held_valid), 32'd0);
        check_eq("t7_ovf", 32'(kq.ovf), 32'd0);
        check_eq("t7_held_key", 32'(kq.held_key), 32'd0);
        idle(RD + 5);
        check_eq("t7_no_rep", 32'(kq.count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
